// File: rtl/redmule_tile_scheduler.sv
// -----------------------------------------------------------------------------
// redmule_tile_scheduler
//
// Walks the RedMulE tile loop nest m (X rows) -> k (W columns) -> n (X columns,
// the reduction axis) from the iteration counts and leftovers handed over by
// the tiler. One tile descriptor is offered per step on a valid/ready
// handshake. Each descriptor carries the indices, the per-axis partial-tile
// flags and the accumulator init/store markers. Completion is reported with a
// single-cycle done pulse.
//
// The walk uses only the three nested counters, so no M*K*N product is ever
// formed. The total schedule length can reach 2^48 tiles without wide
// arithmetic.
// -----------------------------------------------------------------------------
module redmule_tile_scheduler #(
  parameter int unsigned ITER_W = 16,
  parameter int unsigned LFT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ITER_W-1:0] x_rows_iter_i,
  input  logic [ITER_W-1:0] w_cols_iter_i,
  input  logic [ITER_W-1:0] x_cols_iter_i,
  input  logic [LFT_W-1:0]  x_rows_lftovr_i,
  input  logic [LFT_W-1:0]  w_cols_lftovr_i,
  input  logic [LFT_W-1:0]  x_cols_lftovr_i,
  output logic              tile_valid_o,
  input  logic              tile_ready_i,
  output logic [ITER_W-1:0] tile_m_o,
  output logic [ITER_W-1:0] tile_k_o,
  output logic [ITER_W-1:0] tile_n_o,
  output logic              tile_m_lft_o,
  output logic              tile_k_lft_o,
  output logic              tile_n_lft_o,
  output logic              tile_first_o,
  output logic              tile_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ITER_W-1:0] store_cnt_o
);

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ITER_W-1:0] ONE = ITER_W'(1);

  // State, loop indices and completed-store counter
  logic [1:0]        state_q, state_d;
  logic [ITER_W-1:0] m_q, m_d;
  logic [ITER_W-1:0] k_q, k_d;
  logic [ITER_W-1:0] n_q, n_d;
  logic [ITER_W-1:0] store_q, store_d;

  // Configuration latched at start; the tiler outputs may change afterwards
  logic [ITER_W-1:0] m_iter_q, m_iter_d;
  logic [ITER_W-1:0] k_iter_q, k_iter_d;
  logic [ITER_W-1:0] n_iter_q, n_iter_d;
  logic [LFT_W-1:0]  m_lft_q, m_lft_d;
  logic [LFT_W-1:0]  k_lft_q, k_lft_d;
  logic [LFT_W-1:0]  n_lft_q, n_lft_d;

  logic in_run;
  logic handshake;
  logic m_last, k_last, n_last;
  logic any_zero_count;

  assign in_run    = (state_q == RUN);
  assign handshake = in_run && tile_ready_i;

  // Counts are nonzero whenever RUN is entered, so count-1 never wraps here.
  assign m_last = (m_q == (m_iter_q - ONE));
  assign k_last = (k_q == (k_iter_q - ONE));
  assign n_last = (n_q == (n_iter_q - ONE));

  assign any_zero_count = (x_rows_iter_i == '0) ||
                          (w_cols_iter_i == '0) ||
                          (x_cols_iter_i == '0);

  // Next-state logic: FSM, nested index advance and config capture
  always_comb begin
    // NOTE: every signal assigned here first gets a default (hold), so no
    // path through the case/if tree leaves one unassigned and infers a latch.
    state_d  = state_q;
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    store_d  = store_q;
    m_iter_d = m_iter_q;
    k_iter_d = k_iter_q;
    n_iter_d = n_iter_q;
    m_lft_d  = m_lft_q;
    k_lft_d  = k_lft_q;
    n_lft_d  = n_lft_q;

    if (clear_i) begin
      // Soft clear wins over everything, including a coincident start.
      state_d  = IDLE;
      m_d      = '0;
      k_d      = '0;
      n_d      = '0;
      store_d  = '0;
      m_iter_d = '0;
      k_iter_d = '0;
      n_iter_d = '0;
      m_lft_d  = '0;
      k_lft_d  = '0;
      n_lft_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            m_iter_d = x_rows_iter_i;
            k_iter_d = w_cols_iter_i;
            n_iter_d = x_cols_iter_i;
            m_lft_d  = x_rows_lftovr_i;
            k_lft_d  = w_cols_lftovr_i;
            n_lft_d  = x_cols_lftovr_i;
            m_d      = '0;
            k_d      = '0;
            n_d      = '0;
            store_d  = '0;
            // An empty loop nest still completes, it just issues no tiles.
            state_d  = any_zero_count ? DONE : RUN;
          end
        end

        RUN: begin
          if (handshake) begin
            if (n_last) begin
              store_d = store_q + ONE;
              n_d     = '0;
              if (k_last) begin
                k_d = '0;
                if (m_last) begin
                  // Final tile: leave the indices parked at zero.
                  m_d     = '0;
                  state_d = DONE;
                end else begin
                  m_d = m_q + ONE;
                end
              end else begin
                k_d = k_q + ONE;
              end
            end else begin
              n_d = n_q + ONE;
            end
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequential state: FSM, indices and store counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: registers take non-blocking (<=) updates so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      state_q <= IDLE;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
      n_q     <= n_d;
      store_q <= store_d;
    end
  end

  // Sequential state: latched tile-loop configuration
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_iter_q <= '0;
      k_iter_q <= '0;
      n_iter_q <= '0;
      m_lft_q  <= '0;
      k_lft_q  <= '0;
      n_lft_q  <= '0;
    end else begin
      m_iter_q <= m_iter_d;
      k_iter_q <= k_iter_d;
      n_iter_q <= n_iter_d;
      m_lft_q  <= m_lft_d;
      k_lft_q  <= k_lft_d;
      n_lft_q  <= n_lft_d;
    end
  end

  // Descriptor outputs come straight from registers, so they hold steady
  // for as long as the consumer stalls. Flags are qualified with RUN so
  // that idle outputs stay at their reset values.
  assign tile_valid_o = in_run;
  assign tile_m_o     = m_q;
  assign tile_k_o     = k_q;
  assign tile_n_o     = n_q;
  assign tile_m_lft_o = in_run && m_last && (m_lft_q != '0);
  assign tile_k_lft_o = in_run && k_last && (k_lft_q != '0);
  assign tile_n_lft_o = in_run && n_last && (n_lft_q != '0);
  assign tile_first_o = in_run && (n_q == '0);
  assign tile_last_o  = in_run && n_last;
  assign busy_o       = (state_q == RUN) || (state_q == DONE);
  assign done_o       = (state_q == DONE);
  assign store_cnt_o  = store_q;

endmodule

// File: tb/tb_redmule_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_redmule_tile_scheduler
//
// Scoreboard bench: the expected descriptor sequence for a configuration is
// generated from plain nested loops when the start is driven. Each handshaken
// descriptor is popped and compared. Stall stability, done timing, store count,
// clear and async reset behaviour are checked alongside.
// -----------------------------------------------------------------------------
module tb_redmule_tile_scheduler;

  localparam int IW = 16;
  localparam int LW = 8;

  typedef struct packed {
    logic [IW-1:0] m;
    logic [IW-1:0] k;
    logic [IW-1:0] n;
    logic          m_lft;
    logic          k_lft;
    logic          n_lft;
    logic          first;
    logic          last;
  } desc_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          start;
  logic [IW-1:0] x_rows_iter, w_cols_iter, x_cols_iter;
  logic [LW-1:0] x_rows_lft, w_cols_lft, x_cols_lft;
  logic          tile_valid;
  logic          tile_ready;
  logic [IW-1:0] tile_m, tile_k, tile_n;
  logic          tile_m_lft, tile_k_lft, tile_n_lft;
  logic          tile_first, tile_last;
  logic          busy, done;
  logic [IW-1:0] store_cnt;

  desc_t exp_q[$];
  int    exp_stores;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  redmule_tile_scheduler #(
    .ITER_W (IW),
    .LFT_W  (LW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .start_i         (start),
    .x_rows_iter_i   (x_rows_iter),
    .w_cols_iter_i   (w_cols_iter),
    .x_cols_iter_i   (x_cols_iter),
    .x_rows_lftovr_i (x_rows_lft),
    .w_cols_lftovr_i (w_cols_lft),
    .x_cols_lftovr_i (x_cols_lft),
    .tile_valid_o    (tile_valid),
    .tile_ready_i    (tile_ready),
    .tile_m_o        (tile_m),
    .tile_k_o        (tile_k),
    .tile_n_o        (tile_n),
    .tile_m_lft_o    (tile_m_lft),
    .tile_k_lft_o    (tile_k_lft),
    .tile_n_lft_o    (tile_n_lft),
    .tile_first_o    (tile_first),
    .tile_last_o     (tile_last),
    .busy_o          (busy),
    .done_o          (done),
    .store_cnt_o     (store_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic desc_t cur_desc();
    desc_t d;
    d.m     = tile_m;
    d.k     = tile_k;
    d.n     = tile_n;
    d.m_lft = tile_m_lft;
    d.k_lft = tile_k_lft;
    d.n_lft = tile_n_lft;
    d.first = tile_first;
    d.last  = tile_last;
    return d;
  endfunction

  // Reference loop nest: fills the scoreboard for one configuration.
  task automatic push_expected(input int mm, input int kk, input int nn,
                               input int ml, input int kl, input int nl);
    desc_t d;
    exp_stores = 0;
    for (int m = 0; m < mm; m++) begin
      for (int k = 0; k < kk; k++) begin
        for (int n = 0; n < nn; n++) begin
          d.m     = IW'(m);
          d.k     = IW'(k);
          d.n     = IW'(n);
          d.m_lft = (m == mm - 1) && (ml != 0);
          d.k_lft = (k == kk - 1) && (kl != 0);
          d.n_lft = (n == nn - 1) && (nl != 0);
          d.first = (n == 0);
          d.last  = (n == nn - 1);
          if (d.last) exp_stores++;
          exp_q.push_back(d);
        end
      end
    end
  endtask

  task automatic drive_cfg(input int mm, input int kk, input int nn,
                           input int ml, input int kl, input int nl);
    x_rows_iter = IW'(mm);
    w_cols_iter = IW'(kk);
    x_cols_iter = IW'(nn);
    x_rows_lft  = LW'(ml);
    w_cols_lft  = LW'(kl);
    x_cols_lft  = LW'(nl);
  endtask

  // ready_mode: 0 = always ready, 1 = 1,0,1,0 by cycle, 2 = random.
  // restart_at: cycle after which a spurious start is pulsed (-1 = none).
  task automatic run_sched(input int mm, input int kk, input int nn,
                           input int ml, input int kl, input int nl,
                           input int ready_mode, input int restart_at);
    int    hs, last_hs, exp_hs, cyc;
    logic  seen_done, held_v;
    desc_t held, d, e;
    push_expected(mm, kk, nn, ml, kl, nl);
    exp_hs = mm * kk * nn;
    drive_cfg(mm, kk, nn, ml, kl, nl);
    start      = 1'b1;
    tile_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    seen_done = 1'b0;
    held_v    = 1'b0;
    held      = '0;
    hs        = 0;
    last_hs   = 0;
    for (cyc = 1; cyc <= 300 && !seen_done; cyc++) begin
      @(negedge clk);
      d = cur_desc();
      if (cyc == 1) check("first_valid", 64'(tile_valid), 64'(exp_hs != 0));
      if (held_v && tile_valid) check("stall_hold", 64'(d), 64'(held));
      held_v = tile_valid && !tile_ready;
      held   = d;
      if (tile_valid && tile_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_tile", 64'(d), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("tile", 64'(d), 64'(e));
        end
        hs++;
        last_hs = cyc;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", 64'(cyc), 64'(last_hs + 1));
        check("handshakes", 64'(hs), 64'(exp_hs));
        check("store_cnt", 64'(store_cnt), 64'(exp_stores));
        check("done_valid_low", 64'(tile_valid), 64'(0));
      end
      @(posedge clk); #1;
      case (ready_mode)
        1:       tile_ready = ((cyc + 1) % 2) == 1;
        2:       tile_ready = 1'($urandom_range(0, 1));
        default: tile_ready = 1'b1;
      endcase
      start = (cyc == restart_at);
    end
    start = 1'b0;
    if (!seen_done) check("done_timeout", 64'(0), 64'(1));
    @(negedge clk);
    check("post_done_idle", 64'({busy, done, tile_valid}), 64'(0));
    check("store_hold", 64'(store_cnt), 64'(exp_stores));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    tile_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({tile_valid, busy, done, cur_desc(), store_cnt}), 64'(0));
  endtask

  initial begin
    desc_t e;
    rst_n      = 1'b0;
    clear      = 1'b0;
    start      = 1'b0;
    tile_ready = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 2x2x2 walk, ready high: done at cycle 9, four stores.
    run_sched(2, 2, 2, 0, 0, 0, 0, -1);
    // Same with ready toggling 1,0,1,0.
    run_sched(2, 2, 2, 0, 0, 0, 1, -1);
    // Leftovers on m and k, none on n.
    run_sched(3, 1, 2, 5, 7, 0, 0, -1);
    // N=1: first and last together, random ready.
    run_sched(3, 1, 1, 5, 7, 0, 2, -1);
    // Zero reduction count: no tiles, done right away.
    run_sched(2, 2, 0, 0, 0, 0, 0, -1);
    // Spurious start mid-run is ignored; leftover on n too.
    run_sched(2, 3, 2, 1, 0, 3, 0, 4);

    // Soft clear after three handshakes.
    push_expected(2, 2, 2, 0, 0, 0);
    drive_cfg(2, 2, 2, 0, 0, 0);
    start      = 1'b1;
    tile_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("clr_pre_tile", 64'(cur_desc()), 64'(e));
      @(posedge clk); #1;
    end
    clear      = 1'b1;
    tile_ready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("clr_outputs", 64'({tile_valid, busy, done, cur_desc(), store_cnt}), 64'(0));
    @(negedge clk);
    check("clr_no_done", 64'({busy, done}), 64'(0));
    exp_q.delete();
    @(posedge clk); #1;
    run_sched(2, 2, 2, 0, 0, 0, 0, -1);

    // Clear wins over a coincident start.
    drive_cfg(1, 1, 1, 0, 0, 0);
    start = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    check("clr_over_start", 64'({tile_valid, busy, done}), 64'(0));
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run.
    drive_cfg(2, 2, 2, 0, 0, 0);
    start      = 1'b1;
    tile_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n      = 1'b1;
    tile_ready = 1'b0;
    @(posedge clk); #1;
    run_sched(1, 2, 3, 0, 2, 1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/redmule_tile_scheduler.md
# redmule_tile_scheduler

Sequences the RedMulE tile loop nest from the iteration counts and leftovers produced by the tiler. On a start pulse it latches the counts and walks m (X rows) → k (W columns) → n (X columns / reduction), issuing one tile descriptor per step over a valid/ready handshake. Each descriptor carries the tile indices, leftover flags and accumulate-init/store markers. The block sits between the tiler output and the streamer/engine control FSMs and reports completion with a single done pulse.

## Interface
- ITER_W, 16, width of iteration counts and tile indices
- LFT_W, 8, width of leftover fields
- clk_i  in  1  clock
- rst_ni  in  1  reset; reset is asynchronous and active-low
- clear_i  in  1  synchronous soft clear; highest priority
- start_i  in  1  single-cycle start (tiler valid_o)
- x_rows_iter_i / w_cols_iter_i / x_cols_iter_i  in  ITER_W  M / K / N tile counts
- x_rows_lftovr_i / w_cols_lftovr_i / x_cols_lftovr_i  in  LFT_W  residual sizes; 0 means no partial tile
- tile_valid_o  out  1  descriptor valid
- tile_ready_i  in  1  consumer accepts descriptor
- tile_m_o / tile_k_o / tile_n_o  out  ITER_W  current tile indices
- tile_m_lft_o / tile_k_lft_o / tile_n_lft_o  out  1  current tile is the partial (leftover) tile on that axis
- tile_first_o  out  1  n == 0: initialise the accumulator
- tile_last_o  out  1  n == N-1: store Z after this tile
- busy_o  out  1  schedule in progress
- done_o  out  1  single-cycle completion pulse
- store_cnt_o  out  ITER_W  number of handshaken tiles that had tile_last_o set

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i=1:
  - Latch all counts and leftovers.
  - Zero index and store counters.
  - If any count is 0, go to DONE. Otherwise go to RUN.
- start_i is ignored outside IDLE.
- RUN:
  - tile_valid_o=1.
  - Outputs are driven from the latched config and index registers only. They are stable while tile_valid_o && !tile_ready_i.
  - Advance only on a handshake (valid && ready).
- Advance order, on each handshake:
  - n increments.
  - When n == N-1, n wraps to 0 and k increments.
  - When k also == K-1, k wraps to 0 and m increments.
  - The handshake with m==M-1, k==K-1, n==N-1 goes to DONE.
- Per-axis leftover flag: tile_m_lft_o = (m == M-1) && (x_rows_lftovr != 0). k and n follow the same rule with their own count and leftover.
- store_cnt_o increments on each handshake with tile_last_o=1. It holds after completion until the next start or clear.
- DONE: done_o=1 for exactly one cycle, then the FSM returns to IDLE.
- busy_o = 1 in RUN and DONE.
- clear_i from any state:
  - Go to IDLE and zero all registers.
  - No done pulse.
  - clear_i has priority over start_i in the same cycle.
- Arithmetic:
  - Comparisons against count-1 use ITER_W bits.
  - Counts are nonzero in RUN, so no underflow occurs.
  - Total tiles = M·K·N, up to 2^48. No product is ever formed; only the nested counters are used.

## Timing
- Reset values: tile_valid_o=0, busy_o=0, done_o=0, all indices 0, all flags 0, store_cnt_o=0, FSM=IDLE.
- Latency:
  - start_i at cycle t → tile_valid_o=1 at t+1, with the descriptor (0,0,0).
  - Zero-count start at t → done_o=1 at t+1, with tile_valid_o held at 0.
- With ready held high, one tile is issued per cycle. The final handshake at cycle u gives done_o=1 at u+1 and busy_o=0 at u+2.
- tile_valid_o never deasserts in RUN without a handshake (AXI-style valid stability).
- tile_first_o and tile_last_o may both be set when N=1.

## Test plan
- M=2, K=2, N=2, no leftovers, ready=1, start at cycle 0:
  - Tiles (m,k,n) = 000,001,010,011,100,101,110,111 on cycles 1–8.
  - tile_last_o set on odd n.
  - done_o at cycle 9; store_cnt_o=4.
- Same config with ready toggled 1,0,1,0:
  - Descriptors are held unchanged during stalls.
  - The sequence is identical.
  - done_o follows one cycle after the 8th handshake.
- M=3, K=1, N=2 with leftovers x_rows=5, w_cols=7, x_cols=0:
  - tile_m_lft_o=1 only for m=2.
  - tile_k_lft_o=1 on every tile (K=1).
  - tile_n_lft_o always 0.
  - N=1 variant: every tile has first=last=1.
- x_cols_iter=0 start:
  - No tile_valid_o.
  - done_o at start+1; store_cnt_o=0.
- clear_i asserted during RUN after 3 handshakes:
  - Next cycle: IDLE, tile_valid_o=0, indices 0, no done_o.
  - A subsequent start restarts at (0,0,0).
- start_i pulsed again mid-RUN, and rst_ni asserted mid-RUN:
  - Start is ignored and the sequence continues.
  - Reset asynchronously forces all outputs to their reset values.
